router_port: RTL and testbench

- Router-side endpoint of the node↔router byte link: the other end of each Node's put/free/payload handshake.
- RX path: accepts 4 serialized bytes from the node, reassembles a 32-bit packet and queues it for the router crossbar.
- TX path: takes 32-bit packets from the crossbar, queues them and serializes them byte-by-byte to the node.
- One instance per router port.

---
 rtl/router_port.sv | 264 ++++++++++++++++++++++++++
 tb/tb_router_port.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_port.sv
// router_port: router-side endpoint of the node<->router byte link; reassembles RX packets and serializes TX packets.
// Optional destination check is enabled by defining ROUTER_PORT_DEST_CHECK_EN.
module router_port #(
    parameter int unsigned PORTID    = 0,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_NODES = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        put_in,
    input  logic [7:0]  payload_in,
    output logic        free_in,
    output logic        put_out,
    output logic [7:0]  payload_out,
    input  logic        free_out,
    output logic [31:0] rx_pkt,
    output logic        rx_pkt_valid,
    input  logic        rx_pkt_ready,
    input  logic [31:0] tx_pkt,
    input  logic        tx_pkt_valid,
    output logic        tx_pkt_ready,
    output logic        dest_err
);

    localparam int unsigned PKT_W   = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SHIFT_W = PKT_W - BYTE_W;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    // Elaboration-time sanity checks on the configuration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("router_port: DEPTH must be a power of 2 and at least 2");
    end
    if (PORTID > 15 || NUM_NODES > 16) begin : g_bad_ids
        $error("router_port: PORTID and NUM_NODES must fit the 4-bit dest field");
    end

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_R1,
        RX_R2,
        RX_R3
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_S0,
        TX_S1,
        TX_S2,
        TX_S3
    } tx_state_e;

    // RX path state
    rx_state_e          rx_state_q, rx_state_d;
    logic [SHIFT_W-1:0] rx_shift_q, rx_shift_d;
    logic               free_in_q, free_in_d;
    logic               dest_err_q, dest_err_d;
    logic [PKT_W-1:0]   rx_mem_q [DEPTH];
    logic [PKT_W-1:0]   rx_mem_d [DEPTH];
    logic [PTR_W-1:0]   rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PTR_W-1:0]   rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CNT_W-1:0]   rx_count_q, rx_count_d;

    // TX path state
    tx_state_e          tx_state_q, tx_state_d;
    logic [SHIFT_W-1:0] tx_shift_q, tx_shift_d;
    logic               put_out_q, put_out_d;
    logic [BYTE_W-1:0]  payload_out_q, payload_out_d;
    logic [PKT_W-1:0]   tx_mem_q [DEPTH];
    logic [PKT_W-1:0]   tx_mem_d [DEPTH];
    logic [PTR_W-1:0]   tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PTR_W-1:0]   tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CNT_W-1:0]   tx_count_q, tx_count_d;

    logic [PKT_W-1:0]   rx_word_c;
    logic               rx_done_c;
    logic               rx_push_c;
    logic               rx_pop_c;
    logic               tx_full_c;
    logic               tx_push_c;
    logic               tx_pop_c;
    logic [PKT_W-1:0]   tx_head_c;

    assign rx_word_c    = {rx_shift_q, payload_in};
    assign rx_done_c    = (rx_state_q == RX_R3) && put_in;
    assign rx_pkt       = rx_mem_q[rx_rd_ptr_q];
    assign rx_pkt_valid = (rx_count_q != '0);
    assign rx_pop_c     = rx_pkt_valid && rx_pkt_ready;

    assign tx_full_c    = (tx_count_q == CNT_W'(DEPTH));
    assign tx_pkt_ready = !tx_full_c;
    assign tx_push_c    = tx_pkt_valid && tx_pkt_ready;
    assign tx_head_c    = tx_mem_q[tx_rd_ptr_q];
    assign tx_pop_c     = (tx_state_q == TX_IDLE) && (tx_count_q != '0) && free_out;

`ifdef ROUTER_PORT_DEST_CHECK_EN
    logic dest_bad_c;
    // Packets addressed to a non-existent node or back to this port are dropped.
    assign dest_bad_c = (32'(rx_word_c[27:24]) >= NUM_NODES) ||
                        (32'(rx_word_c[27:24]) == PORTID);
    assign rx_push_c  = rx_done_c && !dest_bad_c;
    assign dest_err_d = rx_done_c && dest_bad_c;
`else
    assign rx_push_c  = rx_done_c;
    assign dest_err_d = 1'b0;
`endif

    // RX byte reassembly FSM, MSB first.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (put_in && free_in_q) begin
                    rx_shift_d[23:16] = payload_in;
                    rx_state_d        = RX_R1;
                end
            end
            RX_R1: begin
                if (put_in) begin
                    rx_shift_d[15:8] = payload_in;
                    rx_state_d       = RX_R2;
                end
            end
            RX_R2: begin
                if (put_in) begin
                    rx_shift_d[7:0] = payload_in;
                    rx_state_d      = RX_R3;
                end
            end
            RX_R3: begin
                if (put_in) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX queue bookkeeping; free_in reserves a slot before a packet may start.
    always_comb begin
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_push_c) begin
            rx_mem_d[rx_wr_ptr_q] = rx_word_c;
            rx_wr_ptr_d           = rx_wr_ptr_q + PTR_W'(1);
        end
        if (rx_pop_c) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);
        end
        case ({rx_push_c, rx_pop_c})
            2'b10:   rx_count_d = rx_count_q + CNT_W'(1);
            2'b01:   rx_count_d = rx_count_q - CNT_W'(1);
            default: rx_count_d = rx_count_q;
        endcase
        free_in_d = (rx_state_d == RX_IDLE) && (rx_count_d < CNT_W'(DEPTH));
    end

    // TX queue bookkeeping; ready reflects the pre-edge occupancy only.
    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push_c) begin
            tx_mem_d[tx_wr_ptr_q] = tx_pkt;
            tx_wr_ptr_d           = tx_wr_ptr_q + PTR_W'(1);
        end
        if (tx_pop_c) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
        end
        case ({tx_push_c, tx_pop_c})
            2'b10:   tx_count_d = tx_count_q + CNT_W'(1);
            2'b01:   tx_count_d = tx_count_q - CNT_W'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    // TX serializer FSM: Sk is the cycle in which byte (3-k) is on the link.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_shift_d    = tx_shift_q;
        put_out_d     = 1'b0;
        payload_out_d = payload_out_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_pop_c) begin
                    tx_shift_d    = tx_head_c[23:0];
                    put_out_d     = 1'b1;
                    payload_out_d = tx_head_c[31:24];
                    tx_state_d    = TX_S0;
                end
            end
            TX_S0: begin
                put_out_d     = 1'b1;
                payload_out_d = tx_shift_q[23:16];
                tx_state_d    = TX_S1;
            end
            TX_S1: begin
                put_out_d     = 1'b1;
                payload_out_d = tx_shift_q[15:8];
                tx_state_d    = TX_S2;
            end
            TX_S2: begin
                put_out_d     = 1'b1;
                payload_out_d = tx_shift_q[7:0];
                tx_state_d    = TX_S3;
            end
            TX_S3: begin
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q    <= RX_IDLE;
            rx_shift_q    <= '0;
            free_in_q     <= 1'b0;
            dest_err_q    <= 1'b0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            tx_state_q    <= TX_IDLE;
            tx_shift_q    <= '0;
            put_out_q     <= 1'b0;
            payload_out_q <= '0;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            free_in_q     <= free_in_d;
            dest_err_q    <= dest_err_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            tx_state_q    <= tx_state_d;
            tx_shift_q    <= tx_shift_d;
            put_out_q     <= put_out_d;
            payload_out_q <= payload_out_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

    assign free_in     = free_in_q;
    assign put_out     = put_out_q;
    assign payload_out = payload_out_q;
    assign dest_err    = dest_err_q;

endmodule

// File: tb/tb_router_port.sv
// Directed testbench for router_port: RX reassembly, TX serialization, queue limits, reset, dest check.
module tb_router_port;

    logic        clock;
    logic        reset;
    logic        put_in;
    logic [7:0]  payload_in;
    logic        free_in;
    logic        put_out;
    logic [7:0]  payload_out;
    logic        free_out;
    logic [31:0] rx_pkt;
    logic        rx_pkt_valid;
    logic        rx_pkt_ready;
    logic [31:0] tx_pkt;
    logic        tx_pkt_valid;
    logic        tx_pkt_ready;
    logic        dest_err;

    int n_cmp = 0;
    int n_err = 0;

    router_port #(
        .PORTID   (2),
        .DEPTH    (4),
        .NUM_NODES(6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .put_in      (put_in),
        .payload_in  (payload_in),
        .free_in     (free_in),
        .put_out     (put_out),
        .payload_out (payload_out),
        .free_out    (free_out),
        .rx_pkt      (rx_pkt),
        .rx_pkt_valid(rx_pkt_valid),
        .rx_pkt_ready(rx_pkt_ready),
        .tx_pkt      (tx_pkt),
        .tx_pkt_valid(tx_pkt_valid),
        .tx_pkt_ready(tx_pkt_ready),
        .dest_err    (dest_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for free_in, then send the 4 bytes MSB first on consecutive cycles.
    task automatic rx_send(input logic [31:0] w);
        int n = 0;
        while (!free_in && n < 50) begin
            cyc();
            n++;
        end
        chk("rx_free_wait", 32'(free_in), 32'd1);
        for (int b = 3; b >= 0; b--) begin
            put_in     = 1'b1;
            payload_in = w[b*8 +: 8];
            cyc();
        end
        put_in = 1'b0;
    endtask

    // Wait (bounded) for put_out, then expect 4 bytes followed by an idle cycle.
    task automatic tx_expect(input logic [31:0] w);
        int n = 0;
        while (!put_out && n < 50) begin
            cyc();
            n++;
        end
        for (int b = 3; b >= 0; b--) begin
            chk("tx_put", 32'(put_out), 32'd1);
            chk("tx_byte", 32'(payload_out), 32'(w[b*8 +: 8]));
            cyc();
        end
        chk("tx_gap", 32'(put_out), 32'd0);
        chk("tx_hold", 32'(payload_out), 32'(w[7:0]));
    endtask

    initial begin
        logic [31:0] pk [4];
        logic [31:0] tq [4];
        reset        = 1'b1;
        put_in       = 1'b0;
        payload_in   = 8'h00;
        free_out     = 1'b0;
        rx_pkt_ready = 1'b0;
        tx_pkt       = 32'h0;
        tx_pkt_valid = 1'b0;
        pk[0] = 32'h11111111; pk[1] = 32'h22222222; pk[2] = 32'h33333333; pk[3] = 32'h44444444;
        tq[0] = 32'h10203040; tq[1] = 32'h50607080; tq[2] = 32'h90A0B0C0; tq[3] = 32'hD0E0F001;

        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_free_in", 32'(free_in), 32'd0);
        chk("rst_put_out", 32'(put_out), 32'd0);
        chk("rst_payload_out", 32'(payload_out), 32'd0);
        chk("rst_rx_valid", 32'(rx_pkt_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_pkt_ready), 32'd1);
        chk("rst_dest_err", 32'(dest_err), 32'd0);
        cyc();
        chk("free_in_after_rst", 32'(free_in), 32'd1);

        // Basic RX packet with free_in low through R1..R3
        put_in = 1'b1; payload_in = 8'h12; cyc();
        chk("rx_r1_free", 32'(free_in), 32'd0);
        payload_in = 8'h34; cyc();
        chk("rx_r2_free", 32'(free_in), 32'd0);
        payload_in = 8'h56; cyc();
        chk("rx_r3_free", 32'(free_in), 32'd0);
        chk("rx_r3_valid", 32'(rx_pkt_valid), 32'd0);
        payload_in = 8'h78; cyc();
        put_in = 1'b0;
        chk("rx_valid", 32'(rx_pkt_valid), 32'd1);
        chk("rx_pkt", rx_pkt, 32'h12345678);
        chk("rx_free_back", 32'(free_in), 32'd1);
        rx_pkt_ready = 1'b1; cyc(); rx_pkt_ready = 1'b0;
        chk("rx_popped", 32'(rx_pkt_valid), 32'd0);

        // Basic TX packet
        free_out = 1'b1; tx_pkt = 32'hA1B2C3D4; tx_pkt_valid = 1'b1; cyc();
        tx_pkt_valid = 1'b0;
        chk("tx_not_started", 32'(put_out), 32'd0);
        tx_expect(32'hA1B2C3D4);

        // Fill the RX queue; a byte offered while full is ignored
        for (int i = 0; i < 4; i++) rx_send(pk[i]);
        chk("rx_full_free", 32'(free_in), 32'd0);
        put_in = 1'b1; payload_in = 8'hEE; cyc(); put_in = 1'b0;
        chk("rx_full_free2", 32'(free_in), 32'd0);
        chk("rx_full_head", rx_pkt, pk[0]);
        rx_pkt_ready = 1'b1; cyc(); rx_pkt_ready = 1'b0;
        chk("rx_free_after_pop", 32'(free_in), 32'd1);
        rx_pkt_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("rx_drain_head", rx_pkt, pk[i]);
            cyc();
        end
        rx_pkt_ready = 1'b0;
        chk("rx_drained", 32'(rx_pkt_valid), 32'd0);
        rx_send(32'h5A5AA5A5);
        chk("rx_after_ignore", rx_pkt, 32'h5A5AA5A5);
        rx_pkt_ready = 1'b1; cyc(); rx_pkt_ready = 1'b0;

        // Fill the TX queue with the node busy; a pop while full must not admit a push
        free_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tx_ready_fill", 32'(tx_pkt_ready), 32'd1);
            tx_pkt = tq[i]; tx_pkt_valid = 1'b1; cyc();
        end
        tx_pkt = 32'hDEADBEEF;
        chk("tx_full_ready", 32'(tx_pkt_ready), 32'd0);
        cyc();
        chk("tx_full_idle", 32'(put_out), 32'd0);
        free_out = 1'b1;
        chk("tx_full_ready2", 32'(tx_pkt_ready), 32'd0);
        cyc();
        tx_pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) tx_expect(tq[i]);
        for (int i = 0; i < 6; i++) cyc();
        chk("tx_no_extra", 32'(put_out), 32'd0);

        // Reset in the middle of an RX and a TX packet
        put_in = 1'b1; payload_in = 8'h11; tx_pkt = 32'h99887766; tx_pkt_valid = 1'b1; cyc();
        tx_pkt_valid = 1'b0; payload_in = 8'h22; cyc();
        put_in = 1'b0;
        chk("mid_tx_b3", 32'(payload_out), 32'h99);
        cyc();
        chk("mid_tx_b2", 32'(payload_out), 32'h88);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mrst_put_out", 32'(put_out), 32'd0);
        chk("mrst_payload", 32'(payload_out), 32'd0);
        chk("mrst_rx_valid", 32'(rx_pkt_valid), 32'd0);
        chk("mrst_free_in", 32'(free_in), 32'd0);
        rx_send(32'hCAFEF00D);
        chk("mrst_rx_valid2", 32'(rx_pkt_valid), 32'd1);
        chk("mrst_rx_pkt", rx_pkt, 32'hCAFEF00D);
        chk("mrst_tx_quiet", 32'(put_out), 32'd0);
        rx_pkt_ready = 1'b1; cyc(); rx_pkt_ready = 1'b0;

`ifdef ROUTER_PORT_DEST_CHECK_EN
        rx_send(32'h07000001);
        chk("dc_err1", 32'(dest_err), 32'd1);
        chk("dc_drop1", 32'(rx_pkt_valid), 32'd0);
        chk("dc_free1", 32'(free_in), 32'd1);
        cyc();
        chk("dc_err1_end", 32'(dest_err), 32'd0);
        rx_send(32'h02000001);
        chk("dc_err2", 32'(dest_err), 32'd1);
        chk("dc_drop2", 32'(rx_pkt_valid), 32'd0);
        rx_send(32'h03000001);
        chk("dc_ok_err", 32'(dest_err), 32'd0);
        chk("dc_ok_valid", 32'(rx_pkt_valid), 32'd1);
        chk("dc_ok_pkt", rx_pkt, 32'h03000001);
`else
        rx_send(32'h07000001);
        chk("nodc_err1", 32'(dest_err), 32'd0);
        chk("nodc_pkt1", rx_pkt, 32'h07000001);
        rx_pkt_ready = 1'b1; cyc(); rx_pkt_ready = 1'b0;
        rx_send(32'h02000001);
        chk("nodc_err2", 32'(dest_err), 32'd0);
        chk("nodc_valid2", 32'(rx_pkt_valid), 32'd1);
        chk("nodc_pkt2", rx_pkt, 32'h02000001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
